// File: rtl/ai_move_engine.sv
// Computer-player move selector for an N x N tic-tac-toe board.
// Snapshots both boards, then scans win, block, centre, corner, first free.
module ai_move_engine #(
  parameter int unsigned N    = 3,
  parameter bit          MODE = 1'b1,
  parameter int unsigned IW   = $clog2(N*N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N*N-1:0]  board_own,
  input  logic [N*N-1:0]  board_opp,
  output logic            busy,
  output logic            done,
  output logic            move_valid,
  output logic [N*N-1:0]  move_onehot,
  output logic [IW-1:0]   move_idx,
  output logic            board_full,
  output logic            illegal
);

  localparam int unsigned C   = N * N;
  localparam int unsigned L   = 2 * N + 2;
  localparam int unsigned LW  = $clog2(L);
  localparam int unsigned CTR = (C - 1) / 2;

  typedef enum logic [2:0] {IDLE, CHECK, SCAN_WIN, SCAN_BLK, PICK, DONE} state_t;

  state_t          state;
  logic [LW-1:0]   line;
  logic [C-1:0]    snap_own, snap_opp;
  logic [C-1:0]    scan_a, scan_b, line_mask, line_empty, pick_cell;
  logic            line_hit;

  // Cell mask of line l: rows, columns, main diagonal, anti-diagonal.
  function automatic logic [C-1:0] mask_of(input logic [LW-1:0] l);
    int li;
    mask_of = '0;
    li = int'(l);
    for (int j = 0; j < int'(N); j++) begin
      if (li < int'(N))           mask_of[li*int'(N) + j] = 1'b1;
      else if (li < 2*int'(N))    mask_of[j*int'(N) + li - int'(N)] = 1'b1;
      else if (li == 2*int'(N))   mask_of[j*(int'(N) + 1)] = 1'b1;
      else                        mask_of[(j + 1)*(int'(N) - 1)] = 1'b1;
    end
  endfunction

  function automatic int unsigned pop(input logic [C-1:0] v);
    pop = 0;
    for (int i = 0; i < int'(C); i++) pop = pop + 32'(v[i]);
  endfunction

  function automatic logic [IW-1:0] enc(input logic [C-1:0] oh);
    enc = '0;
    for (int i = 0; i < int'(C); i++)
      if (oh[i]) enc = enc | IW'(i);
  endfunction

  // Line evaluation; block scan swaps the roles of the two boards.
  always_comb begin
    scan_a     = (state == SCAN_BLK) ? snap_opp : snap_own;
    scan_b     = (state == SCAN_BLK) ? snap_own : snap_opp;
    line_mask  = mask_of(line);
    line_empty = line_mask & ~(scan_a | scan_b);
    line_hit   = (pop(scan_a & line_mask) == N - 1) &&
                 (pop(scan_b & line_mask) == 0) &&
                 (pop(line_empty) == 1);
  end

  // Fallback pick: centre, corners, lowest free (full) or highest free (simple).
  always_comb begin
    logic [C-1:0] free;
    int           sel;
    logic         found;
    free      = ~(snap_own | snap_opp);
    sel       = 0;
    found     = 1'b0;
    pick_cell = '0;
    if (MODE) begin
      if ((N % 2) == 1 && free[CTR])  begin sel = int'(CTR);     found = 1'b1; end
      else if (free[0])               begin sel = 0;             found = 1'b1; end
      else if (free[N-1])             begin sel = int'(N) - 1;   found = 1'b1; end
      else if (free[N*(N-1)])         begin sel = int'(N*(N-1)); found = 1'b1; end
      else if (free[C-1])             begin sel = int'(C) - 1;   found = 1'b1; end
      else begin
        for (int i = int'(C) - 1; i >= 0; i--)
          if (free[i]) begin sel = i; found = 1'b1; end
      end
    end else begin
      for (int i = 0; i < int'(C); i++)
        if (free[i]) begin sel = i; found = 1'b1; end
    end
    if (found) pick_cell[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      line        <= '0;
      snap_own    <= '0;
      snap_opp    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      move_valid  <= 1'b0;
      move_onehot <= '0;
      move_idx    <= '0;
      board_full  <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_own    <= board_own;
            snap_opp    <= board_opp;
            move_onehot <= '0;
            move_idx    <= '0;
            board_full  <= 1'b0;
            illegal     <= 1'b0;
            busy        <= 1'b1;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (|(snap_own & snap_opp)) begin
            illegal <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else if (&(snap_own | snap_opp)) begin
            board_full <= 1'b1;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            line  <= '0;
            state <= MODE ? SCAN_WIN : PICK;
          end
        end
        SCAN_WIN, SCAN_BLK: begin
          if (line_hit) begin
            move_onehot <= line_empty;
            move_idx    <= enc(line_empty);
            done        <= 1'b1;
            move_valid  <= 1'b1;
            state       <= DONE;
          end else if (line == LW'(L - 1)) begin
            line  <= '0;
            state <= (state == SCAN_WIN) ? SCAN_BLK : PICK;
          end else begin
            line <= line + LW'(1);
          end
        end
        PICK: begin
          move_onehot <= pick_cell;
          move_idx    <= enc(pick_cell);
          done        <= 1'b1;
          move_valid  <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done       <= 1'b0;
          move_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ai_move_engine.sv
// Directed bench for ai_move_engine: full strategy on 3x3, simple mode on 4x4.
module tb_ai_move_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start3 = 1'b0, start4 = 1'b0;
  logic [8:0]  own3 = '0, opp3 = '0;
  logic [15:0] own4 = '0, opp4 = '0;
  logic        busy3, done3, valid3, full3, ill3;
  logic        busy4, done4, valid4, full4, ill4;
  logic [8:0]  oh3;
  logic [15:0] oh4;
  logic [3:0]  idx3, idx4;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  ai_move_engine #(.N(3), .MODE(1'b1)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .board_own(own3), .board_opp(opp3),
    .busy(busy3), .done(done3), .move_valid(valid3), .move_onehot(oh3),
    .move_idx(idx3), .board_full(full3), .illegal(ill3));

  ai_move_engine #(.N(4), .MODE(1'b0)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .board_own(own4), .board_opp(opp4),
    .busy(busy4), .done(done4), .move_valid(valid4), .move_onehot(oh4),
    .move_idx(idx4), .board_full(full4), .illegal(ill4));

  // Issue one request on the 3x3 engine; returns the cycle done was seen (0 = timeout).
  task automatic run3(input logic [8:0] o, input logic [8:0] p, output int cyc);
    @(negedge clk);
    own3 = o; opp3 = p; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 1;
    while (!done3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!done3) cyc = 0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy3, done3, valid3, oh3, idx3, full3, ill3} !== '0)
      $display("FAIL reset3: got %0h expected 0", {busy3, done3, valid3, oh3, idx3, full3, ill3});
    else pass_cnt++;
    total_cnt++;
    if ({busy4, done4, valid4, oh4, idx4, full4, ill4} !== '0)
      $display("FAIL reset4: got %0h expected 0", {busy4, done4, valid4, oh4, idx4, full4, ill4});
    else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_win;
    int cyc;
    run3(9'h003, 9'h018, cyc);
    total_cnt++;
    if (cyc !== 3) $display("FAIL win_cycle: got %0d expected 3", cyc); else pass_cnt++;
    total_cnt++;
    if ({valid3, idx3, oh3} !== {1'b1, 4'd2, 9'h004})
      $display("FAIL win_move: got valid=%0b idx=%0d oh=%0h expected 1/2/004", valid3, idx3, oh3);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done3, valid3, busy3} !== 3'b000 || oh3 !== 9'h004)
      $display("FAIL win_after: got done=%0b valid=%0b busy=%0b oh=%0h expected 0/0/0/004",
               done3, valid3, busy3, oh3);
    else pass_cnt++;
  endtask

  task automatic test_block;
    int cyc;
    run3(9'h001, 9'h150, cyc);
    total_cnt++;
    if (cyc !== 13) $display("FAIL block_cycle: got %0d expected 13", cyc); else pass_cnt++;
    total_cnt++;
    if ({valid3, idx3, oh3} !== {1'b1, 4'd7, 9'h080})
      $display("FAIL block_move: got valid=%0b idx=%0d oh=%0h expected 1/7/080", valid3, idx3, oh3);
    else pass_cnt++;
  endtask

  task automatic test_pick;
    int cyc;
    run3(9'h000, 9'h000, cyc);
    total_cnt++;
    if (cyc !== 19) $display("FAIL centre_cycle: got %0d expected 19", cyc); else pass_cnt++;
    total_cnt++;
    if ({valid3, idx3, oh3} !== {1'b1, 4'd4, 9'h010})
      $display("FAIL centre_move: got valid=%0b idx=%0d oh=%0h expected 1/4/010", valid3, idx3, oh3);
    else pass_cnt++;
    run3(9'h000, 9'h010, cyc);
    total_cnt++;
    if (cyc !== 19) $display("FAIL corner_cycle: got %0d expected 19", cyc); else pass_cnt++;
    total_cnt++;
    if ({valid3, idx3, oh3} !== {1'b1, 4'd0, 9'h001})
      $display("FAIL corner_move: got valid=%0b idx=%0d oh=%0h expected 1/0/001", valid3, idx3, oh3);
    else pass_cnt++;
  endtask

  task automatic test_errors;
    int cyc;
    run3(9'h1AA, 9'h055, cyc);
    total_cnt++;
    if (cyc !== 2) $display("FAIL full_cycle: got %0d expected 2", cyc); else pass_cnt++;
    total_cnt++;
    if ({full3, ill3, valid3, oh3, idx3} !== {1'b1, 1'b0, 1'b0, 9'h000, 4'd0})
      $display("FAIL full_flags: got full=%0b ill=%0b valid=%0b oh=%0h idx=%0d expected 1/0/0/0/0",
               full3, ill3, valid3, oh3, idx3);
    else pass_cnt++;
    run3(9'h001, 9'h001, cyc);
    total_cnt++;
    if (cyc !== 2) $display("FAIL illegal_cycle: got %0d expected 2", cyc); else pass_cnt++;
    total_cnt++;
    if ({full3, ill3, valid3, oh3, idx3} !== {1'b0, 1'b1, 1'b0, 9'h000, 4'd0})
      $display("FAIL illegal_flags: got full=%0b ill=%0b valid=%0b oh=%0h idx=%0d expected 0/1/0/0/0",
               full3, ill3, valid3, oh3, idx3);
    else pass_cnt++;
  endtask

  task automatic test_simple_mode;
    int cyc;
    int extra;
    @(negedge clk);
    own4 = 16'h4000; opp4 = 16'h8000; start4 = 1'b1;
    @(negedge clk);
    cyc = 1;
    total_cnt++;
    if (busy4 !== 1'b1) $display("FAIL simple_busy: got %0b expected 1", busy4); else pass_cnt++;
    // start stays high through the busy cycles and must be ignored
    while (!done4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b0;
    if (!done4) cyc = 0;
    total_cnt++;
    if (cyc !== 3) $display("FAIL simple_cycle: got %0d expected 3", cyc); else pass_cnt++;
    total_cnt++;
    if ({valid4, idx4, oh4} !== {1'b1, 4'd13, 16'h2000})
      $display("FAIL simple_move: got valid=%0b idx=%0d oh=%0h expected 1/13/2000", valid4, idx4, oh4);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy4, done4} !== 2'b00)
      $display("FAIL simple_busy_fall: got busy=%0b done=%0b expected 0/0", busy4, done4);
    else pass_cnt++;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL simple_ignored_start: got %0d extra done expected 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_midscan;
    int cyc;
    int seen;
    @(negedge clk);
    own3 = 9'h000; opp3 = 9'h000; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy3 !== 1'b1) $display("FAIL midscan_busy: got %0b expected 1", busy3); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({busy3, done3, valid3, oh3, idx3, full3, ill3} !== '0)
      $display("FAIL midscan_reset: got %0h expected 0", {busy3, done3, valid3, oh3, idx3, full3, ill3});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done3 || busy3) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL midscan_no_done: got %0d active cycles expected 0", seen);
    else pass_cnt++;
    run3(9'h003, 9'h018, cyc);
    total_cnt++;
    if (cyc !== 3 || idx3 !== 4'd2)
      $display("FAIL post_reset_win: got cycle=%0d idx=%0d expected 3/2", cyc, idx3);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_win;
    test_block;
    test_pick;
    test_errors;
    test_simple_mode;
    test_reset_midscan;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
